// File: rtl/capture_pkg.sv
// Shared types for the ADC capture path: capture FSM states, trigger-edge encodings, default sample width.
// Pure declarations; no latency, no flow control.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    DONE
  } capture_state_t;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;
  localparam int   DATA_W_DEF   = 12;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port (1-cycle read latency).
// No backpressure; writes and reads are accepted every cycle.
module capture_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_dat_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_dat_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Only the output register is reset, so the array still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_o <= '0;
    end else begin
      rd_dat_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered capture of ADC samples into a circular window, read back in trigger-aligned order.
// rd_data lags rd_addr by one cycle; no backpressure, a sample is taken on every sample_tick.
module adc_capture_buffer
  import capture_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trigger_level,
  input  logic                     trigger_edge,
  input  logic                     force_trig,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [AW-1:0]   PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0]   POST_LAST = AW'(DEPTH - PRE_TRIG - 2);

  capture_state_t    state_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     start_ptr_q;
  logic [AW-1:0]     trig_ptr_q;
  logic [AW-1:0]     cnt_q;
  logic [DATA_W-1:0] prev_q;
  logic              busy_q;
  logic              trig_q;
  logic              done_q;

  logic              wr_en_d;
  logic              rise_d;
  logic              fall_d;
  logic              hit_d;
  logic [AW-1:0]     rd_phys_d;

  assign wr_en_d = sample_tick &&
                   ((state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST_FILL));

  assign rise_d = (prev_q < trigger_level) && (adc_data >= trigger_level);
  assign fall_d = (prev_q > trigger_level) && (adc_data <= trigger_level);
  assign hit_d  = force_trig || ((trigger_edge == TRIG_RISING) ? rise_d : fall_d);

  assign rd_phys_d = start_ptr_q + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      trig_ptr_q  <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      busy_q      <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q  <= PRE_FILL;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        PRE_FILL: begin
          if (sample_tick) begin
            if (cnt_q == PRE_LAST) begin
              state_q <= WAIT_TRIG;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        WAIT_TRIG: begin
          if (sample_tick && hit_d) begin
            state_q    <= POST_FILL;
            trig_ptr_q <= wr_ptr_q;
            cnt_q      <= '0;
            trig_q     <= 1'b1;
          end
        end
        POST_FILL: begin
          // At least one post-trigger tick always follows, so start_ptr settles before DONE.
          start_ptr_q <= trig_ptr_q - PRE_OFF;
          if (sample_tick) begin
            if (cnt_q == POST_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (wr_en_d) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        prev_q   <= adc_data;
      end
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en_d),
    .wr_addr_i(wr_ptr_q),
    .wr_dat_i (adc_data),
    .rd_addr_i(rd_phys_d),
    .rd_dat_o (rd_data)
  );

  assign busy      = busy_q;
  assign triggered = trig_q;
  assign done      = done_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Scoreboard bench for adc_capture_buffer: directed trigger scenarios plus randomized captures
// checked against a sample-history reference model.
module tb_adc_capture_buffer;
  import capture_pkg::*;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int DW    = 12;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          arm = 1'b0;
  logic          trigger_edge = 1'b0;
  logic          force_trig = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [DW-1:0] trigger_level = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          done;

  adc_capture_buffer #(
    .DEPTH   (DEPTH),
    .PRE_TRIG(PRE),
    .DATA_W  (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .adc_data     (adc_data),
    .arm          (arm),
    .trigger_level(trigger_level),
    .trigger_edge (trigger_edge),
    .force_trig   (force_trig),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_rd_q[$];
  int            exp_ra_q[$];
  logic [2:0]    exp_st_q[$];
  bit            rd_req = 1'b0;
  bit            st_req = 1'b0;
  bit            rd_req_d = 1'b0;
  bit            st_req_d = 1'b0;

  // Reference model: the full history of samples written since arm, and where the trigger fell in it.
  typedef enum int {M_IDLE, M_PRE, M_WAIT, M_POST, M_DONE} mphase_t;
  mphase_t       mph = M_IDLE;
  logic [DW-1:0] hist[$];
  int            trig_idx = 0;

  function automatic void model_edge(input bit tk, input logic [DW-1:0] d, input bit a,
                                     input bit f, input bit r);
    bit            hit;
    logic [DW-1:0] p;
    if (r) begin
      mph = M_IDLE;
      hist.delete();
      return;
    end
    case (mph)
      M_IDLE, M_DONE: begin
        if (a) begin
          mph = M_PRE;
          hist.delete();
        end
      end
      default: begin
        if (tk) begin
          hit = 1'b0;
          if (mph == M_WAIT) begin
            p = hist[hist.size()-1];
            if (trigger_edge == TRIG_FALLING) hit = (p > trigger_level) && (d <= trigger_level);
            else                              hit = (p < trigger_level) && (d >= trigger_level);
            hit = hit || f;
          end
          hist.push_back(d);
          if (mph == M_PRE && hist.size() == PRE) mph = M_WAIT;
          else if (mph == M_WAIT && hit) begin
            mph      = M_POST;
            trig_idx = hist.size() - 1;
          end else if (mph == M_POST && hist.size() == trig_idx + DEPTH - PRE) mph = M_DONE;
        end
      end
    endcase
  endfunction

  function automatic logic [2:0] mstat();
    case (mph)
      M_PRE, M_WAIT: return 3'b100;
      M_POST:        return 3'b110;
      M_DONE:        return 3'b011;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic [DW-1:0] win(input int a);
    return hist[trig_idx - PRE + a];
  endfunction

  task automatic step(input bit tk, input logic [DW-1:0] d, input bit a = 1'b0,
                      input bit f = 1'b0, input bit r = 1'b0);
    sample_tick = tk;
    adc_data    = d;
    arm         = a;
    force_trig  = f;
    rst         = r;
    st_req      = 1'b1;
    model_edge(tk, d, a, f, r);
    exp_st_q.push_back(mstat());
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    rd_addr = AW'(a);
    rd_req  = 1'b1;
    exp_rd_q.push_back(e);
    exp_ra_q.push_back(a);
    step(1'b0, '0);
  endtask

  task automatic rst_rd(input int a);
    rd_addr = AW'(a);
    rd_req  = 1'b1;
    exp_rd_q.push_back('0);
    exp_ra_q.push_back(a);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares each presented status/read result against the head of its queue.
  always @(posedge clk) begin
    rd_req_d <= rd_req;
    st_req_d <= st_req;
  end

  always @(negedge clk) begin
    logic [2:0]    es;
    logic [DW-1:0] er;
    int            ea;
    if (st_req_d) begin
      total++;
      if (exp_st_q.size() == 0) begin
        bad++;
        $display("FAIL status: got=%b but no expectation queued", {busy, triggered, done});
      end else begin
        es = exp_st_q.pop_front();
        if ({busy, triggered, done} !== es) begin
          bad++;
          $display("FAIL status {busy,triggered,done}: got=%b want=%b at %0t",
                   {busy, triggered, done}, es, $time);
        end
      end
    end
    if (rd_req_d) begin
      total++;
      if (exp_rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: got=%h but no expectation queued", rd_data);
      end else begin
        er = exp_rd_q.pop_front();
        ea = exp_ra_q.pop_front();
        if (rd_data !== er) begin
          bad++;
          $display("FAIL rd_data[%0d]: got=%h want=%h at %0t", ea, rd_data, er, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_rd(0);
    rst_rd(7);
    step(1'b1, 12'h055);

    // Rising ramp, level 10
    trigger_level = 12'd10;
    trigger_edge  = TRIG_RISING;
    step(1'b0, '0, 1'b1);
    for (int v = 0; v < 22; v++) step(1'b1, DW'(v));
    for (int i = 0; i < 16; i++) rd(i, DW'(6 + i));
    for (int i = 15; i >= 0; i -= 3) rd(i, DW'(6 + i));

    // Falling edge after long WAIT_TRIG, start pointer wraps
    trigger_level = 12'h800;
    trigger_edge  = TRIG_FALLING;
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 34; k++) step(1'b1, 12'hFFF);
    step(1'b1, 12'h700);
    for (int k = 0; k < 11; k++) step(1'b1, DW'(12'h200 + k));
    for (int i = 0; i < 4; i++) rd(i, 12'hFFF);
    rd(4, 12'h700);
    for (int i = 5; i < 16; i++) rd(i, DW'(12'h200 + i - 5));

    // Forced trigger on constant input
    trigger_level = 12'h800;
    trigger_edge  = TRIG_RISING;
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 12'h123);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 12'h123, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) step(1'b1, 12'h123);
    for (int i = 0; i < 16; i++) rd(i, 12'h123);

    // Level equality, crossings in PRE_FILL ignored, arm in WAIT_TRIG ignored
    trigger_level = 12'd5;
    trigger_edge  = TRIG_RISING;
    step(1'b0, '0, 1'b1);
    step(1'b1, 12'd0); step(1'b1, 12'd6); step(1'b1, 12'd4); step(1'b1, 12'd5);
    step(1'b1, 12'd5); step(1'b1, 12'd5); step(1'b1, 12'd5);
    step(1'b0, '0, 1'b1);
    step(1'b1, 12'd4);
    step(1'b1, 12'd5);
    for (int k = 0; k < 11; k++) step(1'b1, DW'(20 + k));
    rd(0, 12'd5); rd(1, 12'd5); rd(2, 12'd5); rd(3, 12'd4); rd(4, 12'd5);
    for (int i = 5; i < 16; i++) rd(i, DW'(20 + i - 5));

    // arm with sample_tick in DONE: sample dropped
    step(1'b1, 12'hABC, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, DW'(100 + k));
    step(1'b1, 12'd104, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) step(1'b1, DW'(105 + k));
    for (int i = 0; i < 16; i++) rd(i, DW'(100 + i));

    // Reset mid-POST_FILL
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, DW'(k));
    step(1'b1, 12'd9, 1'b0, 1'b1);
    step(1'b1, 12'd10);
    step(1'b1, 12'd11);
    rst_rd(3);
    step(1'b1, 12'd12);
    step(1'b1, 12'd13);

    // Randomized captures against the model
    for (int round = 0; round < 8; round++) begin
      trigger_level = DW'($urandom_range(0, 15));
      trigger_edge  = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)), 1'b1);
      for (int cyc = 0; cyc < 300 && mph != M_DONE; cyc++) begin
        step($urandom_range(0, 9) < 7, DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             cyc > 60);
      end
      if (mph == M_DONE) begin
        for (int k = 0; k < 16; k++) begin
          int a;
          a = $urandom_range(0, 15);
          rd(a, win(a));
        end
      end
    end

    step(1'b0, '0);
    @(negedge clk);
    #1;
    total++;
    if (exp_st_q.size() != 0 || exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d status and %0d read expectations left, want 0",
               exp_st_q.size(), exp_rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
